// File: rtl/uart_tx_serializer_if.sv
// Byte-write handshake between the peripheral register block and the UART transmitter.
// The master side writes TX_DATA with a one-cycle TX_EN strobe and watches TX_STATUS
// and tx_overrun. The slave side is the serializer.
interface uart_tx_serializer_if;
    logic [7:0] TX_DATA;
    logic       TX_EN;
    logic       TX_STATUS;
    logic       tx_overrun;

    modport master (
        output TX_DATA,
        output TX_EN,
        input  TX_STATUS,
        input  tx_overrun
    );

    modport slave (
        input  TX_DATA,
        input  TX_EN,
        output TX_STATUS,
        output tx_overrun
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Transmit half of the board UART. It sends 8N1 or 8N2 frames, LSB first, on PC_Uart_txd.
// A holding register sits in front of the shift register, so the CPU can queue the next
// byte while a frame is on the line. Back-to-back frames have no idle gap between them.
module uart_tx_serializer #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int STOP_BITS = 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    uart_tx_serializer_if.slave  bus,
    output logic                 tx_busy,
    output logic                 PC_Uart_txd
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    // The counter must reach the longest phase, which is the stop period.
    localparam int CNT_W        = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_e;

    txState_e         state_q,     state_d;
    logic [CNT_W-1:0] baudCnt_q,   baudCnt_d;
    logic [2:0]       bitIdx_q,    bitIdx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       holdReg_q,   holdReg_d;
    logic             holdValid_q, holdValid_d;
    logic             txd_q,       txd_d;
    logic             overrun_q,   overrun_d;
    logic             accept;

    // A strobe is judged against the pre-edge holding state, even on a transfer edge.
    assign accept    = bus.TX_EN & ~holdValid_q;
    assign overrun_d = bus.TX_EN &  holdValid_q;

    // Register all state. An async reset aborts any frame and sends the line high at once.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            baudCnt_q   <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            holdReg_q   <= '0;
            holdValid_q <= 1'b0;
            txd_q       <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            holdReg_q   <= holdReg_d;
            holdValid_q <= holdValid_d;
            txd_q       <= txd_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next state: accept into the holding register, then sequence START/DATA/STOP on baud ticks.
    always_comb begin
        state_d     = state_q;
        baudCnt_d   = baudCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        holdReg_d   = holdReg_q;
        holdValid_d = holdValid_q;

        if (accept) begin
            holdReg_d   = bus.TX_DATA;
            holdValid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                baudCnt_d = '0;
                bitIdx_d  = '0;
                if (holdValid_q) begin
                    shift_d     = holdReg_q;
                    holdValid_d = 1'b0;
                    state_d     = START;
                end else if (accept) begin
                    // An idle line with an empty shifter skips the holding register, so TX_STATUS never drops.
                    shift_d     = bus.TX_DATA;
                    holdValid_d = 1'b0;
                    state_d     = START;
                end
            end

            START: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q + CNT_ONE;
                end
            end

            DATA: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        shift_d  = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baudCnt_d = baudCnt_q + CNT_ONE;
                end
            end

            STOP: begin
                if (baudCnt_q == STOP_LAST) begin
                    baudCnt_d = '0;
                    if (holdValid_q) begin
                        // A queued byte goes out immediately, with no idle gap between frames.
                        shift_d     = holdReg_q;
                        holdValid_d = 1'b0;
                        state_d     = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d   = IDLE;
                baudCnt_d = '0;
                bitIdx_d  = '0;
            end
        endcase
    end

    // Line level for the current state. It is registered, so txd trails the state by one cycle.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

    assign PC_Uart_txd    = txd_q;
    assign tx_busy        = (state_q != IDLE);
    assign bus.TX_STATUS  = ~holdValid_q;
    assign bus.tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer. It runs two instances, one with one stop bit and one
// with two. A behavioural UART receiver on the first instance pops expected bytes from a
// scoreboard. Per-cycle line and flag checks run against a bench-side model of the frame.
module tb_uart_tx_serializer;

    logic sysclk = 1'b0;
    logic reset;
    logic txBusy0, txd0;
    logic txBusy1, txd1;

    uart_tx_serializer_if bus0();
    uart_tx_serializer_if bus1();

    uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(10), .STOP_BITS(1)) dut0 (
        .sysclk      (sysclk),
        .reset       (reset),
        .bus         (bus0),
        .tx_busy     (txBusy0),
        .PC_Uart_txd (txd0)
    );

    uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(10), .STOP_BITS(2)) dut1 (
        .sysclk      (sysclk),
        .reset       (reset),
        .bus         (bus1),
        .tx_busy     (txBusy1),
        .PC_Uart_txd (txd1)
    );

    // 10 ns system clock.
    always #5 sysclk = ~sysclk;

    int         checkCount = 0;
    int         passCount  = 0;
    int         rxCount    = 0;
    bit         rxAbort    = 1'b0;
    logic [7:0] sbQueue[$];

    // Single comparison point: count it, report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // One-cycle strobe on bus0. It returns at the negedge just after the strobe edge (k=0).
    task automatic applyStimulus(input logic [7:0] data, input bit expectAccept);
        @(negedge sysclk);
        bus0.TX_DATA = data;
        bus0.TX_EN   = 1'b1;
        if (expectAccept) sbQueue.push_back(data);
        @(negedge sysclk);
        bus0.TX_EN   = 1'b0;
    endtask

    // Expected line level k cycles after the strobe edge (one stop bit, idle afterwards).
    function automatic logic expTxd(input int k, input logic [7:0] d);
        logic [7:0] dv;
        dv = d;
        if (k >= 1 && k <= 16)   return 1'b0;
        if (k >= 17 && k <= 144) return dv[(k - 17) / 16];
        return 1'b1;
    endfunction

    // Behavioural UART receiver on dut0. It samples mid-bit and checks each byte against the scoreboard.
    initial begin : rxModel
        logic [7:0] rxByte;
        logic [7:0] expByte;
        logic       startMid;
        logic       stopBit;
        forever begin
            @(negedge sysclk);
            if (reset === 1'b1 && txd0 === 1'b0) begin
                repeat (7) @(negedge sysclk);
                startMid = txd0;
                for (int b = 0; b < 8; b++) begin
                    repeat (16) @(negedge sysclk);
                    rxByte[b] = txd0;
                end
                repeat (16) @(negedge sysclk);
                stopBit = txd0;
                if (rxAbort) begin
                    rxAbort = 1'b0;
                end else begin
                    rxCount++;
                    checkOutput("rx_start", startMid, 0);
                    checkOutput("rx_stop", stopBit, 1);
                    checkOutput("rx_sb_nonempty", sbQueue.size() > 0, 1);
                    if (sbQueue.size() > 0) begin
                        expByte = sbQueue.pop_front();
                        checkOutput("rx_data", rxByte, expByte);
                    end
                end
            end
        end
    end

    // Stop the run if it stalls.
    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence: reset state, single byte, back-to-back, overrun, reset abort, two stop bits, loopback.
    initial begin : mainSeq
        int busyCount;
        int ovCount;
        int waitCycles;

        bus0.TX_EN = 1'b0; bus0.TX_DATA = 8'h00;
        bus1.TX_EN = 1'b0; bus1.TX_DATA = 8'h00;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_txd", txd0, 1);
        checkOutput("rst_status", bus0.TX_STATUS, 1);
        checkOutput("rst_busy", txBusy0, 0);
        checkOutput("rst_overrun", bus0.tx_overrun, 0);
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);

        $display("[TB] single byte 0x55");
        applyStimulus(8'h55, 1'b1);
        checkOutput("t2_txd_k0", txd0, 1);
        checkOutput("t2_busy_k0", txBusy0, 1);
        for (int k = 1; k <= 170; k++) begin
            @(negedge sysclk);
            checkOutput("t2_txd", txd0, expTxd(k, 8'h55));
            checkOutput("t2_busy", txBusy0, k <= 159);
            checkOutput("t2_status", bus0.TX_STATUS, 1);
        end

        $display("[TB] back-to-back 0xA5, 0x3C");
        applyStimulus(8'hA5, 1'b1);
        busyCount = txBusy0 ? 1 : 0;
        bus0.TX_DATA = 8'h3C;
        bus0.TX_EN   = 1'b1;
        sbQueue.push_back(8'h3C);
        for (int k = 1; k <= 340; k++) begin
            @(negedge sysclk);
            if (k == 1) bus0.TX_EN = 1'b0;
            if (txBusy0) busyCount++;
            checkOutput("t3_status", bus0.TX_STATUS, k >= 160);
            checkOutput("t3_txd", txd0, (k <= 160) ? expTxd(k, 8'hA5) : expTxd(k - 160, 8'h3C));
        end
        checkOutput("t3_busy_cycles", busyCount, 320);

        $display("[TB] overrun 0x11, 0x22, 0x33");
        @(negedge sysclk);
        bus0.TX_DATA = 8'h11;
        bus0.TX_EN   = 1'b1;
        sbQueue.push_back(8'h11);
        @(negedge sysclk);
        checkOutput("t4_overrun_k0", bus0.tx_overrun, 0);
        ovCount = 0;
        bus0.TX_DATA = 8'h22;
        sbQueue.push_back(8'h22);
        @(negedge sysclk);
        checkOutput("t4_overrun_k1", bus0.tx_overrun, 0);
        checkOutput("t4_status_k1", bus0.TX_STATUS, 0);
        bus0.TX_DATA = 8'h33;
        @(negedge sysclk);
        bus0.TX_EN = 1'b0;
        checkOutput("t4_overrun_k2", bus0.tx_overrun, 1);
        if (bus0.tx_overrun === 1'b1) ovCount++;
        for (int k = 3; k <= 342; k++) begin
            @(negedge sysclk);
            if (bus0.tx_overrun === 1'b1) ovCount++;
        end
        checkOutput("t4_overrun_pulses", ovCount, 1);
        checkOutput("t4_idle_busy", txBusy0, 0);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h55, 1'b0);
        bus0.TX_DATA = 8'h99;
        bus0.TX_EN   = 1'b1;
        @(negedge sysclk);
        bus0.TX_EN = 1'b0;
        repeat (39) @(negedge sysclk);
        checkOutput("t1_txd_pre", txd0, 0);
        checkOutput("t1_status_pre", bus0.TX_STATUS, 0);
        rxAbort = 1'b1;
        #2 reset = 1'b0;
        #1;
        checkOutput("t1_txd", txd0, 1);
        checkOutput("t1_status", bus0.TX_STATUS, 1);
        checkOutput("t1_busy", txBusy0, 0);
        repeat (4) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        checkOutput("t1_busy_release", txBusy0, 0);
        repeat (200) @(negedge sysclk);
        checkOutput("t1_txd_idle", txd0, 1);
        applyStimulus(8'h0F, 1'b1);
        busyCount = txBusy0 ? 1 : 0;
        for (int k = 1; k <= 170; k++) begin
            @(negedge sysclk);
            if (txBusy0) busyCount++;
            checkOutput("t1_txd_after", txd0, expTxd(k, 8'h0F));
        end
        checkOutput("t1_busy_cycles", busyCount, 160);

        $display("[TB] two stop bits 0xFF");
        @(negedge sysclk);
        bus1.TX_DATA = 8'hFF;
        bus1.TX_EN   = 1'b1;
        @(negedge sysclk);
        bus1.TX_EN   = 1'b0;
        busyCount = txBusy1 ? 1 : 0;
        for (int k = 1; k <= 190; k++) begin
            @(negedge sysclk);
            if (txBusy1) busyCount++;
            checkOutput("t5_txd", txd1, expTxd(k, 8'hFF));
            checkOutput("t5_busy", txBusy1, k <= 175);
            checkOutput("t5_status", bus1.TX_STATUS, 1);
        end
        checkOutput("t5_busy_cycles", busyCount, 176);

        $display("[TB] loopback 0x00, 0xFF, 0x5A");
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        waitCycles = 0;
        while (bus0.TX_STATUS !== 1'b1 && waitCycles < 400) begin
            @(negedge sysclk);
            waitCycles++;
        end
        checkOutput("t6_status_wait", bus0.TX_STATUS, 1);
        applyStimulus(8'h5A, 1'b1);
        waitCycles = 0;
        while (txBusy0 !== 1'b0 && waitCycles < 1000) begin
            @(negedge sysclk);
            waitCycles++;
        end
        checkOutput("t6_idle_wait", txBusy0, 0);
        repeat (20) @(negedge sysclk);

        checkOutput("sb_empty", sbQueue.size(), 0);
        checkOutput("rx_count", rxCount, 9);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
